// File: rtl/audiolevel_overlay_if.sv
// Video bus for the audio level overlay.
// Inputs: active_in, hsyncn_in, vsyncn_in, r_in, g_in, b_in (source raster).
// Outputs: active_out, hsyncn_out, vsyncn_out, r_out, g_out, b_out (composited, 2-cycle delay).
// Syncs are active-low. The slave modport is the overlay; the master modport is the source/sink side.
interface audiolevel_overlay_if;
    logic       active_in;
    logic       hsyncn_in;
    logic       vsyncn_in;
    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic       active_out;
    logic       hsyncn_out;
    logic       vsyncn_out;
    logic [7:0] r_out;
    logic [7:0] g_out;
    logic [7:0] b_out;

    modport master (
        output active_in, hsyncn_in, vsyncn_in, r_in, g_in, b_in,
        input  active_out, hsyncn_out, vsyncn_out, r_out, g_out, b_out
    );

    modport slave (
        input  active_in, hsyncn_in, vsyncn_in, r_in, g_in, b_in,
        output active_out, hsyncn_out, vsyncn_out, r_out, g_out, b_out
    );
endinterface

// File: rtl/audiolevel_overlay.sv
// Multi-channel audio level meter overlay.
// Draws one horizontal bar per PCM channel (per-frame peak level with linear decay
// plus a peak-hold marker) over the incoming raster. Video latency is 2 clk cycles.
// Ports:
//   clk, reset      pixel clock, synchronous active-high reset
//   mute            ignore samples while high
//   bar_color       RGB888 fill colour {R,G,B}
//   pcm_fs          one-cycle sample strobe
//   pcm_data        CHANNELS signed samples, channel k at [k*PCM_WIDTH +: PCM_WIDTH]
//   vid             video in/out bus (slave side)
module audiolevel_overlay #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned PCM_WIDTH   = 16,
    parameter int unsigned LEN_LOG2    = 8,
    parameter int unsigned BAR_X       = 32,
    parameter int unsigned BAR_Y       = 32,
    parameter int unsigned BAR_HEIGHT  = 8,
    parameter int unsigned BAR_GAP     = 4,
    parameter int unsigned DECAY_STEP  = 4,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned XY_WIDTH    = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            mute,
    input  logic [23:0]                     bar_color,
    input  logic                            pcm_fs,
    input  logic [CHANNELS*PCM_WIDTH-1:0]   pcm_data,
    audiolevel_overlay_if.slave             vid
);

    localparam int unsigned LW     = LEN_LOG2;
    localparam int unsigned HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int unsigned PITCH  = BAR_HEIGHT + BAR_GAP;
    localparam logic [LW-1:0]     DECAY     = LW'(DECAY_STEP);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

    logic                 vs_q;
    logic                 act_q;
    logic                 tick;
    logic                 line_end;
    logic                 sample_en;
    logic [XY_WIDTH-1:0]  x;
    logic [XY_WIDTH-1:0]  y;

    logic [PCM_WIDTH-1:0] smp      [CHANNELS];
    logic [PCM_WIDTH-1:0] mag_abs  [CHANNELS];
    logic [LW-1:0]        mag      [CHANNELS];
    logic [LW-1:0]        cap      [CHANNELS];
    logic [LW-1:0]        level    [CHANNELS];
    logic [LW-1:0]        peak     [CHANNELS];
    logic [HOLD_W-1:0]    hold     [CHANNELS];
    logic [LW-1:0]        level_dec[CHANNELS];
    logic [LW-1:0]        peak_dec [CHANNELS];
    logic [LW-1:0]        level_nxt[CHANNELS];

    logic                 marker_hit;
    logic                 fill_hit;
    logic [31:0]          row_lo;

    logic                 s1_act;
    logic                 s1_hs;
    logic                 s1_vs;
    logic [23:0]          s1_rgb;
    logic                 s1_marker;
    logic                 s1_fill;

    assign tick      = vs_q & ~vid.vsyncn_in;
    assign line_end  = act_q & ~vid.active_in;
    assign sample_en = pcm_fs & ~mute;

    // Per-channel magnitude: |sample| (most negative saturates), top LEN_LOG2 bits below the sign.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            smp[k]     = pcm_data[k*PCM_WIDTH +: PCM_WIDTH];
            mag_abs[k] = smp[k][PCM_WIDTH-1] ? (~smp[k] + PCM_WIDTH'(1)) : smp[k];
            if (mag_abs[k][PCM_WIDTH-1]) begin
                mag_abs[k] = {1'b0, {(PCM_WIDTH-1){1'b1}}};
            end
            mag[k] = LW'(mag_abs[k] >> (PCM_WIDTH - 1 - LEN_LOG2));
        end
    end

    // Frame-tick arithmetic: decayed level/peak and the level loaded at the tick.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            level_dec[k] = (level[k] > DECAY) ? (level[k] - DECAY) : '0;
            peak_dec[k]  = (peak[k]  > DECAY) ? (peak[k]  - DECAY) : '0;
            level_nxt[k] = (cap[k] > level_dec[k]) ? cap[k] : level_dec[k];
        end
    end

    // Capture, level, peak and hold state; levels only move at the frame tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                cap[k]   <= '0;
                level[k] <= '0;
                peak[k]  <= '0;
                hold[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (tick) begin
                    level[k] <= level_nxt[k];
                    // A strobe on the tick cycle belongs to the new frame.
                    cap[k]   <= sample_en ? mag[k] : '0;
                    if (level_nxt[k] >= peak[k]) begin
                        peak[k] <= level_nxt[k];
                        hold[k] <= HOLD_INIT;
                    end else if (hold[k] != '0) begin
                        hold[k] <= hold[k] - HOLD_W'(1);
                    end else begin
                        peak[k] <= peak_dec[k];
                    end
                end else if (sample_en && (mag[k] > cap[k])) begin
                    cap[k] <= mag[k];
                end
            end
        end
    end

    // Raster position of the current input pixel; both counters saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q  <= 1'b1;
            act_q <= 1'b0;
            x     <= '0;
            y     <= '0;
        end else begin
            vs_q  <= vid.vsyncn_in;
            act_q <= vid.active_in;
            if (!vid.active_in) begin
                x <= '0;
            end else if (x != '1) begin
                x <= x + XY_WIDTH'(1);
            end
            if (tick) begin
                y <= '0;
            end else if (line_end && (y != '1)) begin
                y <= y + XY_WIDTH'(1);
            end
        end
    end

    // Hit test against every bar for the current pixel.
    always_comb begin
        marker_hit = 1'b0;
        fill_hit   = 1'b0;
        row_lo     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            row_lo = 32'(BAR_Y + k * PITCH);
            if ((32'(y) >= row_lo) && (32'(y) < row_lo + 32'(BAR_HEIGHT))) begin
                if ((peak[k] != '0) && (32'(x) == 32'(BAR_X) + 32'(peak[k]))) begin
                    marker_hit = 1'b1;
                end
                if ((32'(x) >= 32'(BAR_X)) && (32'(x) < 32'(BAR_X) + 32'(level[k]))) begin
                    fill_hit = 1'b1;
                end
            end
        end
    end

    // Stage 1: delayed video plus hit flags (overlay only during active video).
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_act    <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_rgb    <= '0;
            s1_marker <= 1'b0;
            s1_fill   <= 1'b0;
        end else begin
            s1_act    <= vid.active_in;
            s1_hs     <= vid.hsyncn_in;
            s1_vs     <= vid.vsyncn_in;
            s1_rgb    <= {vid.r_in, vid.g_in, vid.b_in};
            s1_marker <= vid.active_in & marker_hit;
            s1_fill   <= vid.active_in & fill_hit;
        end
    end

    // Stage 2: colour mux, marker over fill over source.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid.active_out <= 1'b0;
            vid.hsyncn_out <= 1'b1;
            vid.vsyncn_out <= 1'b1;
            {vid.r_out, vid.g_out, vid.b_out} <= '0;
        end else begin
            vid.active_out <= s1_act;
            vid.hsyncn_out <= s1_hs;
            vid.vsyncn_out <= s1_vs;
            if (s1_marker) begin
                {vid.r_out, vid.g_out, vid.b_out} <= 24'hFF_FFFF;
            end else if (s1_fill) begin
                {vid.r_out, vid.g_out, vid.b_out} <= bar_color;
            end else begin
                {vid.r_out, vid.g_out, vid.b_out} <= s1_rgb;
            end
        end
    end

endmodule

// File: tb/tb_audiolevel_overlay.sv
// Bench for audiolevel_overlay: a 2-channel and a 4-channel instance share one
// video stream; a frame-level behavioural model predicts every output pixel.
`timescale 1ns/1ps
module tb_audiolevel_overlay;

    localparam int LINE_W = 292;
    localparam int LINES  = 80;
    localparam logic [23:0] COLOR = 24'h3C_A0_5A;
    localparam logic [26:0] RST_VID = {1'b0, 1'b1, 1'b1, 24'h0};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        mute = 1'b0;
    logic        pcm_fs = 1'b0;
    logic [31:0] pcm_a;
    logic [63:0] pcm_b;
    int          smp [4];

    logic        act = 1'b0;
    logic        hs = 1'b1;
    logic        vs = 1'b1;
    logic [7:0]  rin = 8'h0;
    logic [7:0]  gin = 8'h0;
    logic [7:0]  bin = 8'h0;
    int          cur_x = 0;
    int          cur_y = 0;
    int          cyc = 0;

    int          n_checks = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;

    // Model state, index 0 = 2-channel DUT, 1 = 4-channel DUT.
    int          m_cap   [2][4];
    int          m_level [2][4];
    int          m_peak  [2][4];
    int          m_hold  [2][4];
    bit          m_prev_vs [2];
    logic [26:0] exp1 [2];
    logic [26:0] exp2 [2];

    audiolevel_overlay_if va();
    audiolevel_overlay_if vb();

    always_comb begin
        pcm_a = {16'(smp[1]), 16'(smp[0])};
        pcm_b = {16'(smp[3]), 16'(smp[2]), 16'(smp[1]), 16'(smp[0])};
    end

    assign va.active_in = act;
    assign va.hsyncn_in = hs;
    assign va.vsyncn_in = vs;
    assign va.r_in = rin;
    assign va.g_in = gin;
    assign va.b_in = bin;
    assign vb.active_in = act;
    assign vb.hsyncn_in = hs;
    assign vb.vsyncn_in = vs;
    assign vb.r_in = rin;
    assign vb.g_in = gin;
    assign vb.b_in = bin;

    audiolevel_overlay #(.CHANNELS(2)) dut_a (
        .clk(clk), .reset(reset), .mute(mute), .bar_color(COLOR),
        .pcm_fs(pcm_fs), .pcm_data(pcm_a), .vid(va)
    );

    audiolevel_overlay #(.CHANNELS(4)) dut_b (
        .clk(clk), .reset(reset), .mute(mute), .bar_color(COLOR),
        .pcm_fs(pcm_fs), .pcm_data(pcm_b), .vid(vb)
    );

    function automatic int nch(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int mag_of(input int s);
        int a;
        a = (s < 0) ? -s : s;
        if (a > 32767) a = 32767;
        return a / 128;
    endfunction

    function automatic int sat_dec(input int v);
        return (v > 4) ? v - 4 : 0;
    endfunction

    // Expected composited pixel for the current input, using the levels shown this frame.
    function automatic logic [26:0] pixel_exp(input int d);
        logic [26:0] v;
        int hit;
        int lo;
        v = {act, hs, vs, rin, gin, bin};
        hit = 0;
        if (act) begin
            for (int k = 0; k < nch(d); k++) begin
                lo = 32 + 12 * k;
                if (cur_y >= lo && cur_y < lo + 8) begin
                    if (m_peak[d][k] > 0 && cur_x == 32 + m_peak[d][k]) hit = 2;
                    else if (hit == 0 && cur_x >= 32 && cur_x < 32 + m_level[d][k]) hit = 1;
                end
            end
        end
        if (hit == 2) v[23:0] = 24'hFF_FFFF;
        else if (hit == 1) v[23:0] = COLOR;
        return v;
    endfunction

    // Advance the model by one clock edge with the inputs presented at that edge.
    task automatic model_edge();
        bit tick;
        bit take;
        int m;
        int nl;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int k = 0; k < 4; k++) begin
                    m_cap[d][k] = 0; m_level[d][k] = 0; m_peak[d][k] = 0; m_hold[d][k] = 0;
                end
                exp1[d] = RST_VID;
                exp2[d] = RST_VID;
                m_prev_vs[d] = 1'b1;
            end else begin
                exp2[d] = exp1[d];
                exp1[d] = pixel_exp(d);
                tick = m_prev_vs[d] && !vs;
                m_prev_vs[d] = vs;
                take = pcm_fs && !mute;
                for (int k = 0; k < nch(d); k++) begin
                    m = mag_of(smp[k]);
                    if (tick) begin
                        nl = (m_cap[d][k] > sat_dec(m_level[d][k])) ? m_cap[d][k] : sat_dec(m_level[d][k]);
                        m_level[d][k] = nl;
                        if (nl >= m_peak[d][k]) begin
                            m_peak[d][k] = nl;
                            m_hold[d][k] = 30;
                        end else if (m_hold[d][k] > 0) begin
                            m_hold[d][k]--;
                        end else begin
                            m_peak[d][k] = sat_dec(m_peak[d][k]);
                        end
                        m_cap[d][k] = take ? m : 0;
                    end else if (take && m > m_cap[d][k]) begin
                        m_cap[d][k] = m;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic chk_vid(input string name, input logic [26:0] got, input logic [26:0] expv);
        n_checks++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d, x=%0d y=%0d)", name, got, expv, cyc, cur_x, cur_y);
        end
    endtask

    // Per-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk_vid("vid_2ch", {va.active_out, va.hsyncn_out, va.vsyncn_out, va.r_out, va.g_out, va.b_out}, exp2[0]);
            chk_vid("vid_4ch", {vb.active_out, vb.hsyncn_out, vb.vsyncn_out, vb.r_out, vb.g_out, vb.b_out}, exp2[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        if (reset) chk_en = 1'b1;
        #1;
        cyc++;
    endtask

    task automatic pix(input bit a, input bit h, input bit v, input int x, input int y);
        act = a; hs = h; vs = v; cur_x = x; cur_y = y;
        rin = 8'(x); gin = 8'(y * 3); bin = 8'(cyc);
        step();
    endtask

    function automatic bit full_line(input int l);
        int lo;
        for (int k = 0; k < 4; k++) begin
            lo = 32 + 12 * k;
            if (l == lo - 1 || l == lo || l == lo + 7 || l == lo + 8) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic sample(input int s0, input int s1, input int s2, input int s3);
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        pcm_fs = 1'b1;
        pix(0, 1, 1, 0, 0);
        pcm_fs = 1'b0;
    endtask

    // One frame: vsync pulse (tick on its first cycle), then optionally the active raster.
    task automatic frame(input bit render, input bit fs_on_tick, input int rst_line);
        int len;
        pcm_fs = fs_on_tick;
        pix(0, 1, 0, 0, 0);
        pcm_fs = 1'b0;
        pix(0, 1, 0, 0, 0);
        pix(0, 1, 1, 0, 0);
        pix(0, 1, 1, 0, 0);
        if (render) begin
            for (int l = 0; l < LINES; l++) begin
                len = full_line(l) ? LINE_W : 4;
                for (int x = 0; x < len; x++) begin
                    if (l == rst_line && x == 100) begin
                        reset = 1'b1;
                        pix(1, 1, 1, x, l);
                        reset = 1'b0;
                        chk("rst_active_out", int'(va.active_out), 0);
                        chk("rst_hsyncn_out", int'(va.hsyncn_out), 1);
                        chk("rst_vsyncn_out", int'(vb.vsyncn_out), 1);
                        chk("rst_rgb_out", int'({vb.r_out, vb.g_out, vb.b_out}), 0);
                    end else begin
                        pix(1, 1, 1, x, l);
                    end
                end
                pix(0, 1, 1, 0, l);
                pix(0, 0, 1, 0, l);
                pix(0, 0, 1, 0, l);
                pix(0, 1, 1, 0, l);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) smp[k] = 0;
        repeat (3) pix(0, 1, 1, 0, 0);
        reset = 1'b0;
        pix(0, 1, 1, 0, 0);
        pix(0, 1, 1, 0, 0);

        // Muted samples are ignored: plain pass-through frame.
        mute = 1'b1;
        sample(20000, -20000, 20000, 20000);
        frame(1'b1, 1'b0, -1);
        chk("mute_level0", m_level[1][0], 0);
        chk("mute_level3", m_level[1][3], 0);
        mute = 1'b0;

        // Full scale, back-to-back strobes; capture keeps the per-channel max.
        sample(-32768, 100, 8192, 2000);
        sample(5, 16384, 0, 0);
        frame(1'b1, 1'b0, -1);
        chk("fs_level0", m_level[1][0], 255);
        chk("fs_level1", m_level[1][1], 128);
        chk("fs_level2", m_level[1][2], 64);
        chk("fs_level3", m_level[1][3], 15);
        chk("fs_peak0", m_peak[0][0], 255);

        // Decay and peak hold with silence.
        frame(1'b1, 1'b0, -1);
        chk("decay_t2_level0", m_level[1][0], 251);
        chk("decay_t2_peak0", m_peak[1][0], 255);
        repeat (29) frame(1'b0, 1'b0, -1);
        chk("decay_t31_peak0", m_peak[1][0], 255);
        chk("decay_t31_level0", m_level[1][0], 135);
        frame(1'b0, 1'b0, -1);
        chk("decay_t32_peak0", m_peak[1][0], 251);
        chk("decay_t32_level0", m_level[1][0], 131);
        frame(1'b1, 1'b0, -1);
        chk("decay_t33_peak1", m_peak[1][1], 120);
        chk("decay_t33_level1", m_level[1][1], 0);
        repeat (32) frame(1'b0, 1'b0, -1);
        chk("decay_t65_level0", m_level[1][0], 0);
        chk("decay_t65_peak0", m_peak[1][0], 119);
        repeat (30) frame(1'b0, 1'b0, -1);
        chk("decay_t95_peak0", m_peak[1][0], 0);

        // Strobe on the tick cycle belongs to the new frame.
        sample(6400, 0, 0, 0);
        smp[0] = 12800;
        frame(1'b0, 1'b1, -1);
        chk("simul_level_n", m_level[1][0], 50);
        frame(1'b1, 1'b0, -1);
        chk("simul_level_n1", m_level[1][0], 100);
        chk("simul_peak_n1", m_peak[0][0], 100);

        // Reset mid-line with a bar showing, then a bar-free frame.
        frame(1'b1, 1'b0, 32);
        chk("rst_model_level0", m_level[1][0], 0);
        frame(1'b1, 1'b0, -1);

        pix(0, 1, 1, 0, 0);
        pix(0, 1, 1, 0, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/audiolevel_overlay.md
# audiolevel_overlay

Parametrised multi-channel audio level meter overlay, the successor to the two-channel sound bar. It sits in the pixel-clock domain between the video source and `hdmi_tx`, and overlays one horizontal bar per PCM channel onto the incoming raster. Each bar shows the per-frame peak level with linear decay, plus a peak-hold marker. All video signals pass through with a fixed, equal latency.

## Interface
- `CHANNELS`, 2: number of PCM channels and bars (1–8).
- `PCM_WIDTH`, 16: signed sample width.
- `LEN_LOG2`, 8: maximum bar length is 2^LEN_LOG2 pixels.
- `BAR_X`, 32: first active pixel column of all bars.
- `BAR_Y`, 32: first active line of bar 0.
- `BAR_HEIGHT`, 8: lines per bar.
- `BAR_GAP`, 4: blank lines between bars.
- `DECAY_STEP`, 4: level/peak decrement per frame, in pixels.
- `HOLD_FRAMES`, 30: frames a peak marker holds before it decays.
- `XY_WIDTH`, 12: width of the raster x/y counters.

Ports (clock and reset first):
- `clk` in 1: pixel clock; sole clock.
- `reset` in 1: synchronous, active-high reset.
- `mute` in 1: when 1, samples are ignored and capture stays 0.
- `bar_color` in 24: RGB888 fill colour {R,G,B}.
- `pcm_fs` in 1: one-cycle sample strobe; synchronous to `clk`.
- `pcm_data` in CHANNELS*PCM_WIDTH: channel k occupies bits [k*PCM_WIDTH +: PCM_WIDTH].
- `active_in`, `hsyncn_in`, `vsyncn_in` in 1 each: video timing, syncs active-low.
- `r_in`, `g_in`, `b_in` in 8 each: source pixel.
- `active_out`, `hsyncn_out`, `vsyncn_out` out 1 each: delayed timing.
- `r_out`, `g_out`, `b_out` out 8 each: composited pixel.

## Operation
- **Sample capture.**
  - Per channel: abs = |sample|, with -2^(PCM_WIDTH-1) saturating to 2^(PCM_WIDTH-1)-1.
  - mag = abs[PCM_WIDTH-2 -: LEN_LOG2].
  - On `pcm_fs` with `mute`=0: cap[k] <= max(cap[k], mag).
- **Frame tick.** The frame tick fires on the `vsyncn_in` falling edge, detected from a registered copy. At the tick, for each k:
  - `level[k]` <= max(cap[k], level[k] saturating-minus DECAY_STEP).
  - cap[k] <= 0. If `pcm_fs` coincides with the tick, that sample's mag is loaded into cap instead of 0, i.e. it belongs to the new frame.
  - Peak update:
    - If the new level ≥ peak[k]: peak <= new level and hold[k] <= HOLD_FRAMES.
    - Else if hold[k] ≠ 0: hold decrements.
    - Else: peak <= peak saturating-minus DECAY_STEP.
- **Raster counters.**
  - x counts active pixels and clears when `active_in` is 0.
  - y increments on each `active_in` falling edge and clears on the frame tick.
  - Both counters saturate at all-ones and never wrap.
- **Bar geometry.**
  - Bar k covers lines y in [BAR_Y + k*(BAR_HEIGHT+BAR_GAP), +BAR_HEIGHT).
  - Fill covers x in [BAR_X, BAR_X + level[k]).
  - The peak marker is the single column x = BAR_X + peak[k], drawn only when peak[k] > 0.
- **Composite.** Priority: marker (0xFFFFFF) > fill (`bar_color`) > source pixel. Overlay applies only while `active_in`=1; blanking pixels pass through unchanged.
- **Level display timing.** Levels change only at frame ticks, so a bar never tears mid-frame.
- **Reset.** `reset`=1 clears cap, level, peak, hold, counters and all pipeline stages on the next edge.

## Timing
- Video latency is exactly 2 `clk` cycles for `active`, `hsyncn`, `vsyncn` and RGB.
- Stage 1 computes the hit test; stage 2 applies the colour mux and registers the outputs.
- Output values during and after reset, until valid data fills the pipe:
  - `active_out` = 0.
  - `hsyncn_out` = 1.
  - `vsyncn_out` = 1.
  - `r_out`/`g_out`/`b_out` = 0.
- Reset asserted mid-frame: outputs take their reset values on the next edge. After release, the first two output cycles carry the reset values, then normal pass-through resumes. Bars stay empty until the first sample after the following frame tick.
- A level captured in frame N is displayed in frame N+1.
- `pcm_fs` may assert on any cycle, including back-to-back cycles.

## Test plan
- **Pass-through.** `mute`=1, ramp RGB input → outputs equal inputs delayed 2 cycles. Syncs match after 2 cycles; no bar pixels drawn.
- **Full-scale.** Ch0 sample -32768, ch1 +16384, LEN_LOG2=8, then one frame tick → next frame shows bar 0 fill of 255 px and bar 1 fill of 128 px starting at x=32. The markers sit at columns 287 and 160.
- **Decay/hold.** One 255 level, then silence → fill drops by 4 each frame (251, 247, …). The marker stays at 255 for 30 frames, then drops by 4 per frame. Both floors are 0.
- **Simultaneous tick.** `pcm_fs` with mag 100 on the same cycle as the vsync falling edge → the frame-N level excludes 100; the frame-N+1 level is 100.
- **Reset mid-frame.** Assert `reset` for 1 cycle mid-line with levels nonzero → next-edge outputs are 0/1/1/0. The following frame shows no bars.
- **CHANNELS=4.** Distinct amplitudes per channel → four bars at y = 32, 44, 56, 68, each with correct length; no overlap between bars.
